// File: rtl/ysyx_22040210_trap_ctrl_pkg.sv
// rtl/ysyx_22040210_trap_ctrl_pkg.sv - shared CSR addresses and mstatus bit positions
package ysyx_22040210_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    // Pseudo-address: the CSR file writes mepc and mcause together on this one strobe
    localparam logic [11:0] CSR_ECALL   = 12'hfff;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/ysyx_22040210_trap_ctrl_if.sv
// rtl/ysyx_22040210_trap_ctrl_if.sv - pipeline request and CSR port bundle for the trap controller
interface ysyx_22040210_trap_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
);
    logic              req_valid_i;
    logic              ecall_i;
    logic              mret_i;
    logic [XLEN-1:0]   pc_i;
    logic              ready_o;
    logic              stall_o;
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              csr_re_o;
    logic [CSR_AW-1:0] csr_raddr_o;
    logic [XLEN-1:0]   csr_rdata_i;
    logic              redirect_valid_o;
    logic [XLEN-1:0]   redirect_pc_o;

    modport slave (
        input  req_valid_i, ecall_i, mret_i, pc_i, csr_rdata_i,
        output ready_o, stall_o, csr_we_o, csr_waddr_o, csr_wdata_o,
               csr_re_o, csr_raddr_o, redirect_valid_o, redirect_pc_o
    );

    modport master (
        output req_valid_i, ecall_i, mret_i, pc_i, csr_rdata_i,
        input  ready_o, stall_o, csr_we_o, csr_waddr_o, csr_wdata_o,
               csr_re_o, csr_raddr_o, redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/ysyx_22040210_trap_ctrl.sv
// rtl/ysyx_22040210_trap_ctrl.sv - ecall/mret sequencer: CSR updates then a one-cycle PC redirect
module ysyx_22040210_trap_ctrl
    import ysyx_22040210_trap_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int CSR_AW     = 12,
    parameter int ECALL_CODE = 11
) (
    input  logic clk,
    input  logic rst,
    ysyx_22040210_trap_ctrl_if.slave bus
);

    if (ECALL_CODE < 0 || XLEN < 13 || CSR_AW < 12) begin : g_bad_params
        $error("trap_ctrl: unsupported XLEN/CSR_AW/ECALL_CODE");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_E_EPC  = 3'd1,
        S_E_STAT = 3'd2,
        S_R_STAT = 3'd3,
        S_R_WR   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, status_q, target_q;
    logic            take_ecall;

    function automatic logic [XLEN-1:0] ecall_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                 = s;
        r[MSTATUS_MPIE]                   = s[MSTATUS_MIE];
        r[MSTATUS_MIE]                    = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = PRIV_M;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                 = s;
        r[MSTATUS_MIE]                    = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                   = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = PRIV_M;
        return r;
    endfunction

    assign take_ecall = (state_q == S_IDLE) && bus.req_valid_i && bus.ecall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            status_q <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (take_ecall)
                pc_q <= bus.pc_i;
            if (state_q == S_E_EPC || state_q == S_R_STAT)
                status_q <= bus.csr_rdata_i;
            // Only direct-mode vectors are supported, so the mode bits are dropped
            if (state_q == S_E_STAT || state_q == S_R_WR)
                target_q <= {bus.csr_rdata_i[XLEN-1:2], 2'b00};
        end
    end

    // Read and write addresses always differ in a cycle, keeping the CSR bypass acyclic
    always_comb begin
        state_d              = state_q;
        bus.ready_o          = 1'b0;
        bus.stall_o          = 1'b1;
        bus.csr_we_o         = 1'b0;
        bus.csr_waddr_o      = '0;
        bus.csr_wdata_o      = '0;
        bus.csr_re_o         = 1'b0;
        bus.csr_raddr_o      = '0;
        bus.redirect_valid_o = 1'b0;
        bus.redirect_pc_o    = '0;
        case (state_q)
            S_IDLE: begin
                bus.ready_o = 1'b1;
                bus.stall_o = 1'b0;
                if (bus.req_valid_i) begin
                    if (bus.ecall_i)
                        state_d = S_E_EPC;
                    else if (bus.mret_i)
                        state_d = S_R_STAT;
                end
            end
            S_E_EPC: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = CSR_AW'(CSR_ECALL);
                bus.csr_wdata_o = pc_q;
                bus.csr_re_o    = 1'b1;
                bus.csr_raddr_o = CSR_AW'(CSR_MSTATUS);
                state_d         = S_E_STAT;
            end
            S_E_STAT: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                bus.csr_wdata_o = ecall_status(status_q);
                bus.csr_re_o    = 1'b1;
                bus.csr_raddr_o = CSR_AW'(CSR_MTVEC);
                state_d         = S_DONE;
            end
            S_R_STAT: begin
                bus.csr_re_o    = 1'b1;
                bus.csr_raddr_o = CSR_AW'(CSR_MSTATUS);
                state_d         = S_R_WR;
            end
            S_R_WR: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                bus.csr_wdata_o = mret_status(status_q);
                bus.csr_re_o    = 1'b1;
                bus.csr_raddr_o = CSR_AW'(CSR_MEPC);
                state_d         = S_DONE;
            end
            S_DONE: begin
                bus.redirect_valid_o = 1'b1;
                bus.redirect_pc_o    = target_q;
                state_d              = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/ysyx_22040210_trap_ctrl.md
YSYX_22040210_TRAP_CTRL -- requirements
Module: ysyx_22040210_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 64, data/PC width.
REQ-002 SHALL have parameter CSR_AW, 12, CSR address width, matching the CSR file address bus.
REQ-003 SHALL have parameter ECALL_CODE, 11, mcause value written on ecall from M-mode.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, 1, EX stage presents a trap instruction.
REQ-007 SHALL have port ecall_i, input, 1, request is ecall.
REQ-008 SHALL have port mret_i, input, 1, request is mret.
REQ-009 SHALL have port pc_i, input, XLEN, PC of the requesting instruction.
REQ-010 SHALL have port ready_o, output, 1, request accepted this cycle.
REQ-011 SHALL have port stall_o, output, 1, freeze IF/ID/EX while busy.
REQ-012 SHALL have port csr_we_o, output, 1, CSR file write enable.
REQ-013 SHALL have port csr_waddr_o, output, CSR_AW, CSR write address.
REQ-014 SHALL have port csr_wdata_o, output, XLEN, CSR write data.
REQ-015 SHALL have port csr_re_o, output, 1, CSR read enable for read port 2.
REQ-016 SHALL have port csr_raddr_o, output, CSR_AW, CSR read address for port 2.
REQ-017 SHALL have port csr_rdata_i, input, XLEN, CSR read data from port 2, combinational.
REQ-018 SHALL have port redirect_valid_o, output, 1, one-cycle PC redirect and pipeline flush.
REQ-019 SHALL have port redirect_pc_o, output, XLEN, redirect target.

Function
REQ-020 SHALL implement an FSM with states IDLE, E_EPC, E_STAT, R_STAT, R_WR and DONE.
REQ-021 ready_o SHALL be 1 only in IDLE, and a request SHALL be accepted when req_valid_i & ready_o; ecall SHALL win over mret when both are set, and req_valid_i with neither flag SHALL be ignored.
REQ-022 On accepting an ecall, the block SHALL latch pc_i into pc_q and go to E_EPC.
REQ-023 In E_EPC: we=1, waddr=ECALL pseudo-address, wdata=pc_q (CSR file sets mepc and mcause=ECALL_CODE); re=1, raddr=MSTATUS; status_q<=csr_rdata_i; next state E_STAT.
REQ-024 In E_STAT: we=1, waddr=MSTATUS, wdata=status_q with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11; re=1, raddr=MTVEC; target_q<={rdata[63:2],2'b00} (direct mode only); next state DONE.
REQ-025 On accepting an mret, the block SHALL go to R_STAT.
REQ-026 In R_STAT: re=1, raddr=MSTATUS; status_q<=rdata; we=0; next state R_WR.
REQ-027 In R_WR: we=1, waddr=MSTATUS, wdata=status_q with MIE<=MPIE, MPIE<=1, MPP<=2'b11; re=1, raddr=MEPC; target_q<={rdata[63:2],2'b00}; next state DONE.
REQ-028 In DONE: redirect_valid_o=1 for exactly one cycle, redirect_pc_o=target_q; next state IDLE.
REQ-029 raddr SHALL never equal waddr while both we and re are 1, so that no combinational loop forms through the CSR bypass path.
REQ-030 stall_o SHALL be 1 in every state except IDLE.
REQ-031 Latency from acceptance to redirect_valid_o SHALL be 3 cycles for both ecall and mret.
REQ-032 When not driven by the active state, csr_we_o, csr_re_o and redirect_valid_o SHALL be 0, and the address/data outputs SHALL be 0.
REQ-033 A new request SHALL NOT be accepted in DONE; the earliest back-to-back acceptance SHALL be in the cycle after DONE.

Reset
REQ-034 While rst=1: state=IDLE; pc_q, status_q and target_q SHALL be 0; every output SHALL be 0 except ready_o=1.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence immediately, with no further CSR write or redirect issued.

Structure
REQ-036 CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342), the ECALL pseudo-address, and the mstatus bit positions SHALL come from the shared define file.
REQ-037 FSM state encodings SHALL be defined as local constants; no sub-module is required.

Verification
REQ-038 Bench SHALL cover: after reset, mtvec=0x80000104, ecall at pc=0x80000010 -> mepc=0x80000010, mcause=11, mstatus=0xa00001800, redirect 0x80000104 exactly 3 cycles after acceptance.
REQ-039 Bench SHALL cover: mstatus=0x1808 (MIE=1), ecall -> mstatus=0x1880.
REQ-040 Bench SHALL cover: mstatus=0x1880, mepc=0x80000014, mret -> mstatus=0x1888, redirect 0x80000014 at cycle 3.
REQ-041 Bench SHALL cover: ecall_i and mret_i both set -> ecall sequence taken; req_valid_i held through DONE -> second acceptance occurs only in the cycle after DONE.
REQ-042 Bench SHALL cover: rst pulsed in E_STAT -> no redirect, state IDLE, mtvec and mepc unchanged thereafter.
REQ-043 Bench SHALL cover: assertion that we&&re&&(waddr==raddr) never holds in any cycle.
